// File: rtl/sid_dac_rx_if.sv
// sid_dac_rx_if: the five pins of the SID serial dual-DAC link.
// master = serializer side (drives pins), slave = receiver side.
interface sid_dac_rx_if;
  logic dac_clk;
  logic dac_dat_1;
  logic dac_dat_2;
  logic dac_leb;
  logic dac_csb;

  modport master (output dac_clk, output dac_dat_1, output dac_dat_2,
                  output dac_leb, output dac_csb);
  modport slave  (input dac_clk, input dac_dat_1, input dac_dat_2,
                  input dac_leb, input dac_csb);
endinterface

// File: rtl/sid_dac_rx.sv
// sid_dac_rx: oversampling receiver for the SID serial dual-DAC link.
// Recovers one 16-bit word per DAC per frame, commits bits 11:0 to the
// channel input register picked by bit 15, and copies all input registers
// to the sample outputs while the load strobe is low.
// Optional feature macro: SID_DAC_RX_SHDN_EN -- a committed word with
// SHDNb (bit 12) low stores RESET_CODE instead of its data bits.
module sid_dac_rx #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] RESET_CODE  = 12'h000
) (
  input  logic          clk_i,
  input  logic          rst_n,
  sid_dac_rx_if.slave   link,
  output logic [11:0]   sample_1a,
  output logic [11:0]   sample_1b,
  output logic [11:0]   sample_2a,
  output logic [11:0]   sample_2b,
  output logic          upd,
  output logic          frame_err
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit positions inside the synchronized pin bundle.
  localparam int PIN_CLK = 0;
  localparam int PIN_D1  = 1;
  localparam int PIN_D2  = 2;
  localparam int PIN_LEB = 3;
  localparam int PIN_CSB = 4;
  // Idle link level: clk=0, dat=0, leb=1, csb=1.
  localparam logic [4:0] PIN_IDLE = 5'b11000;

  logic [4:0]  pins_s;
  logic [4:0]  sync_r [SYNC_STAGES];
  logic [4:0]  cur_s;
  logic [4:0]  hist_r;

  logic        csb_fall_s;
  logic        csb_rise_s;
  logic        sclk_rise_s;
  logic        leb_low_s;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        clear_s;
  logic        shift_s;
  logic        close_s;

  logic [4:0]  bit_cnt_r;
  logic [15:0] sh1_r;
  logic [15:0] sh2_r;
  logic [11:0] val1_s;
  logic [11:0] val2_s;
  logic        good_frame_s;

  logic [11:0] in_1a_r;
  logic [11:0] in_1b_r;
  logic [11:0] in_2a_r;
  logic [11:0] in_2b_r;

  logic        unused_s;

  assign pins_s = {link.dac_csb, link.dac_leb, link.dac_dat_2,
                   link.dac_dat_1, link.dac_clk};

  // Synchronizer chain on all five pins followed by one history stage.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= PIN_IDLE;
      end
      hist_r <= PIN_IDLE;
    end else begin
      sync_r[0] <= pins_s;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign cur_s       = sync_r[SYNC_STAGES-1];
  assign csb_fall_s  = hist_r[PIN_CSB] & ~cur_s[PIN_CSB];
  assign csb_rise_s  = ~hist_r[PIN_CSB] & cur_s[PIN_CSB];
  assign sclk_rise_s = ~hist_r[PIN_CLK] & cur_s[PIN_CLK];
  assign leb_low_s   = ~cur_s[PIN_LEB];

  // Frame state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame FSM: open on csb fall, shift on sclk rise, close on csb rise.
  // A clock edge coinciding with the close is dropped.
  always_comb begin
    state_nxt_s = state_r;
    clear_s     = 1'b0;
    shift_s     = 1'b0;
    close_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (csb_fall_s) begin
          state_nxt_s = ST_SHIFT;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (csb_rise_s) begin
          state_nxt_s = ST_IDLE;
          close_s     = 1'b1;
        end else if (sclk_rise_s) begin
          state_nxt_s = ST_SHIFT;
          shift_s     = 1'b1;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign good_frame_s = close_s && (bit_cnt_r == 5'd16);

`ifdef SID_DAC_RX_SHDN_EN
  assign val1_s = sh1_r[12] ? sh1_r[11:0] : RESET_CODE;
  assign val2_s = sh2_r[12] ? sh2_r[11:0] : RESET_CODE;
`else
  assign val1_s = sh1_r[11:0];
  assign val2_s = sh2_r[11:0];
`endif

  // Shift registers, saturating bit counter and word commit to input regs.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      bit_cnt_r <= 5'd0;
      sh1_r     <= 16'h0000;
      sh2_r     <= 16'h0000;
      in_1a_r   <= RESET_CODE;
      in_1b_r   <= RESET_CODE;
      in_2a_r   <= RESET_CODE;
      in_2b_r   <= RESET_CODE;
    end else begin
      if (clear_s) begin
        bit_cnt_r <= 5'd0;
        sh1_r     <= 16'h0000;
        sh2_r     <= 16'h0000;
      end else if (shift_s) begin
        sh1_r <= {sh1_r[14:0], cur_s[PIN_D1]};
        sh2_r <= {sh2_r[14:0], cur_s[PIN_D2]};
        if (bit_cnt_r != 5'd31) begin
          bit_cnt_r <= bit_cnt_r + 5'd1;
        end
      end
      if (good_frame_s) begin
        if (sh1_r[15]) begin
          in_1b_r <= val1_s;
        end else begin
          in_1a_r <= val1_s;
        end
        if (sh2_r[15]) begin
          in_2b_r <= val2_s;
        end else begin
          in_2a_r <= val2_s;
        end
      end
    end
  end

  // Level-sensitive output transfer plus upd and frame_err pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      sample_1a <= RESET_CODE;
      sample_1b <= RESET_CODE;
      sample_2a <= RESET_CODE;
      sample_2b <= RESET_CODE;
      upd       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= close_s && (bit_cnt_r != 5'd16);
      upd       <= leb_low_s &&
                   ({in_1a_r, in_1b_r, in_2a_r, in_2b_r} !=
                    {sample_1a, sample_1b, sample_2a, sample_2b});
      if (leb_low_s) begin
        sample_1a <= in_1a_r;
        sample_1b <= in_1b_r;
        sample_2a <= in_2a_r;
        sample_2b <= in_2b_r;
      end
    end
  end

  // Bits that carry no meaning for this receiver.
  assign unused_s = ^{sh1_r[14:12], sh2_r[14:12], hist_r[PIN_D1],
                      hist_r[PIN_D2], hist_r[PIN_LEB]};

endmodule
